// File: rtl/parity_frame_loader.sv
// Serial loader and result collector for the 16-input parity cone: builds 16+1 bit frames,
// drives the cone, checks its q against the received parity bit and hands results downstream.
module parity_frame_loader #(
  parameter int PAR_LAT = 1,
  parameter bit ODD     = 1'b0,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_valid,
  input  logic             ser_data,
  output logic             ser_ready,
  output logic [15:0]      par_word,
  input  logic             par_q,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_word,
  output logic             res_err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    SHIFT = 2'd0,
    EVAL  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [2:0]       SETTLE_LAST = 3'(PAR_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t      state;
  state_t      next_state;
  logic [4:0]  bit_idx;
  logic [15:0] shift_reg;
  logic        par_bit;
  logic [2:0]  settle_cnt;
  logic        take;
  logic        settle_done;
  logic        err_now;

  assign take        = ser_valid & ser_ready;
  // The counter starts at 0 on the parity edge, so q is sampled PAR_LAT+1 edges later.
  assign settle_done = (settle_cnt == SETTLE_LAST);
  assign err_now     = par_q ^ par_bit ^ ODD;

  always_ff @(posedge clk) begin
    if (rst) state <= SHIFT;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      SHIFT: if (take && bit_idx == 5'd16) next_state = EVAL;
      EVAL:  if (settle_done) next_state = HOLD;
      HOLD:  if (res_ready) next_state = SHIFT;
      default: next_state = SHIFT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx    <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      settle_cnt <= '0;
      par_word   <= '0;
      res_word   <= '0;
      res_err    <= 1'b0;
      res_valid  <= 1'b0;
      err_cnt    <= '0;
      ser_ready  <= 1'b0;
    end else begin
      // Registered ready keeps the serial side free of combinational paths.
      ser_ready <= (next_state == SHIFT);
      case (state)
        SHIFT: begin
          if (take) begin
            if (bit_idx == 5'd16) begin
              par_word   <= shift_reg;
              par_bit    <= ser_data;
              settle_cnt <= '0;
              bit_idx    <= '0;
            end else begin
              shift_reg <= {shift_reg[14:0], ser_data};
              bit_idx   <= bit_idx + 5'd1;
            end
          end
        end
        EVAL: begin
          if (settle_done) begin
            res_word  <= par_word;
            res_err   <= err_now;
            res_valid <= 1'b1;
            if (err_now && err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 3'd1;
          end
        end
        HOLD: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: begin
          bit_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_loader.sv
// Self-checking bench: three loader instances (even/odd parity, PAR_LAT 1/3, narrow counter)
// each driving an XOR cone model, checked against a table and a frame-level reference model.
module tb_parity_frame_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        ser_valid [3];
  logic        ser_data  [3];
  logic        ser_ready [3];
  logic        par_q     [3];
  logic        res_valid [3];
  logic        res_ready [3];
  logic        res_err   [3];
  logic [15:0] par_word  [3];
  logic [15:0] res_word  [3];
  logic [7:0]  err_cnt0, err_cnt1;
  logic [1:0]  err_cnt2;
  logic [7:0]  err_cnt   [3];

  int tests  = 0;
  int failed = 0;
  int model_cnt [3];

  typedef struct {
    int          dut;
    logic [15:0] word;
    logic        pbit;
    bit          gaps;
    int          hold;
    logic        exp_err;
    int          exp_cnt;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  assign err_cnt[0] = err_cnt0;
  assign err_cnt[1] = err_cnt1;
  assign err_cnt[2] = {6'd0, err_cnt2};

  // Behavioural cone: q is the XOR of all sixteen inputs.
  for (genvar g = 0; g < 3; g++) begin : g_cone
    assign par_q[g] = ^par_word[g];
  end

  parity_frame_loader #(.PAR_LAT(1), .ODD(1'b0), .CNT_W(8)) u_even (
    .clk(clk), .rst(rst), .ser_valid(ser_valid[0]), .ser_data(ser_data[0]),
    .ser_ready(ser_ready[0]), .par_word(par_word[0]), .par_q(par_q[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_word(res_word[0]),
    .res_err(res_err[0]), .err_cnt(err_cnt0));

  parity_frame_loader #(.PAR_LAT(1), .ODD(1'b1), .CNT_W(8)) u_odd (
    .clk(clk), .rst(rst), .ser_valid(ser_valid[1]), .ser_data(ser_data[1]),
    .ser_ready(ser_ready[1]), .par_word(par_word[1]), .par_q(par_q[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_word(res_word[1]),
    .res_err(res_err[1]), .err_cnt(err_cnt1));

  parity_frame_loader #(.PAR_LAT(3), .ODD(1'b0), .CNT_W(2)) u_slow (
    .clk(clk), .rst(rst), .ser_valid(ser_valid[2]), .ser_data(ser_data[2]),
    .ser_ready(ser_ready[2]), .par_word(par_word[2]), .par_q(par_q[2]),
    .res_valid(res_valid[2]), .res_ready(res_ready[2]), .res_word(res_word[2]),
    .res_err(res_err[2]), .err_cnt(err_cnt2));

  function automatic int lat_of(input int d);
    return (d == 2) ? 3 : 1;
  endfunction

  function automatic logic odd_of(input int d);
    return (d == 1) ? 1'b1 : 1'b0;
  endfunction

  function automatic int max_of(input int d);
    return (d == 2) ? 3 : 255;
  endfunction

  function automatic logic model_err(input int d, input logic [15:0] word, input logic pbit);
    return (^word) ^ pbit ^ odd_of(d);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Offers one serial bit to instance d, optionally after a random idle gap, and waits for it to transfer.
  task automatic applyStimulus(input int d, input logic b, input bit gaps);
    int  n;
    int  g;
    bit  rdy;
    g = gaps ? int'($urandom_range(0, 2)) : 0;
    ser_valid[d] = 1'b0;
    for (int k = 0; k < g; k++) begin
      @(posedge clk); #1;
    end
    ser_valid[d] = 1'b1;
    ser_data[d]  = b;
    n = 0;
    do begin
      rdy = ser_ready[d];
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) checkOutput("ser_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_frame(input int d, input logic [15:0] word, input logic pbit, input bit gaps,
                           input int hold, input logic exp_err, input int exp_cnt);
    int lat;
    bit seen;
    for (int i = 15; i >= 0; i--) applyStimulus(d, word[i], gaps);
    applyStimulus(d, pbit, gaps);
    ser_valid[d] = 1'b0;
    checkOutput("par_word", par_word[d], word);
    checkOutput("ser_ready_eval", ser_ready[d], 0);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      seen = res_valid[d];
    end
    checkOutput("res_valid_seen", seen, 1);
    checkOutput("latency", lat, lat_of(d) + 1);
    checkOutput("res_word", res_word[d], word);
    checkOutput("res_err", res_err[d], exp_err);
    checkOutput("err_cnt", err_cnt[d], exp_cnt);
    if (model_err(d, word, pbit) && model_cnt[d] < max_of(d)) model_cnt[d]++;
    for (int k = 0; k < hold; k++) begin
      ser_valid[d] = 1'b1;
      ser_data[d]  = 1'($urandom);
      @(posedge clk); #1;
      checkOutput("hold_ser_ready", ser_ready[d], 0);
      checkOutput("hold_res_valid", res_valid[d], 1);
      checkOutput("hold_res_word", res_word[d], word);
      checkOutput("hold_res_err", res_err[d], exp_err);
    end
    ser_valid[d] = 1'b0;
    res_ready[d] = 1'b1;
    @(posedge clk); #1;
    res_ready[d] = 1'b0;
    checkOutput("handshake_res_valid", res_valid[d], 0);
    checkOutput("handshake_ser_ready", ser_ready[d], 1);
    checkOutput("par_word_kept", par_word[d], word);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      checkOutput("rst_ser_ready", ser_ready[d], 0);
      checkOutput("rst_par_word", par_word[d], 0);
      checkOutput("rst_res_word", res_word[d], 0);
      checkOutput("rst_res_err", res_err[d], 0);
      checkOutput("rst_res_valid", res_valid[d], 0);
      checkOutput("rst_err_cnt", err_cnt[d], 0);
      model_cnt[d] = 0;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) checkOutput("post_rst_ser_ready", ser_ready[d], 1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{dut: 0, word: 16'hA5A5, pbit: 1'b0, gaps: 1'b0, hold: 10, exp_err: 1'b0, exp_cnt: 0};
    vecs[1] = '{dut: 0, word: 16'h0001, pbit: 1'b0, gaps: 1'b0, hold: 0,  exp_err: 1'b1, exp_cnt: 1};
    vecs[2] = '{dut: 1, word: 16'h0001, pbit: 1'b0, gaps: 1'b0, hold: 0,  exp_err: 1'b0, exp_cnt: 0};
    vecs[3] = '{dut: 1, word: 16'hA5A5, pbit: 1'b0, gaps: 1'b0, hold: 2,  exp_err: 1'b1, exp_cnt: 1};
    vecs[4] = '{dut: 2, word: 16'h0003, pbit: 1'b1, gaps: 1'b1, hold: 0,  exp_err: 1'b1, exp_cnt: 1};
    vecs[5] = '{dut: 2, word: 16'h0003, pbit: 1'b1, gaps: 1'b1, hold: 0,  exp_err: 1'b1, exp_cnt: 2};
    vecs[6] = '{dut: 2, word: 16'h0003, pbit: 1'b1, gaps: 1'b1, hold: 1,  exp_err: 1'b1, exp_cnt: 3};
    vecs[7] = '{dut: 2, word: 16'h0003, pbit: 1'b1, gaps: 1'b1, hold: 0,  exp_err: 1'b1, exp_cnt: 3};
    vecs[8] = '{dut: 2, word: 16'h0003, pbit: 1'b1, gaps: 1'b1, hold: 0,  exp_err: 1'b1, exp_cnt: 3};
    vecs[9] = '{dut: 0, word: 16'h1234, pbit: 1'b1, gaps: 1'b1, hold: 0,  exp_err: 1'b0, exp_cnt: 1};

    for (int d = 0; d < 3; d++) begin
      ser_valid[d] = 1'b0;
      ser_data[d]  = 1'b0;
      res_ready[d] = 1'b0;
    end
    do_reset();

    foreach (vecs[i])
      run_frame(vecs[i].dut, vecs[i].word, vecs[i].pbit, vecs[i].gaps, vecs[i].hold,
                vecs[i].exp_err, vecs[i].exp_cnt);

    for (int n = 0; n < 12; n++) begin
      int          d;
      logic [15:0] w;
      logic        p;
      int          c;
      d = int'($urandom_range(0, 2));
      w = 16'($urandom);
      p = 1'($urandom);
      c = model_cnt[d];
      if (model_err(d, w, p) && c < max_of(d)) c++;
      run_frame(d, w, p, 1'b1, int'($urandom_range(0, 3)), model_err(d, w, p), c);
    end

    // Reset after nine data bits: the partial frame must leave no trace.
    for (int i = 0; i < 9; i++) applyStimulus(0, 1'b1, 1'b0);
    ser_valid[0] = 1'b0;
    do_reset();
    run_frame(0, 16'h1234, 1'b1, 1'b0, 0, 1'b0, 0);
    run_frame(2, 16'h8000, 1'b0, 1'b1, 0, 1'b1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
